// File: rtl/data_write_buffer_if.sv
// SRAM-like request/response bus: a request transfers on req & addr_ok,
// and one data_ok follows later for each transfer, in order.
interface data_write_buffer_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_write_buffer.sv
// Write buffer between an upstream SRAM-like port and a downstream one: writes
// complete upstream immediately and drain in order; reads wait for an empty buffer.
module data_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_write_buffer_if.slave   s,
    data_write_buffer_if.master  m,
    output logic                 buf_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_REQ  = 3'd1;
    localparam logic [2:0] W_WAIT = 3'd2;
    localparam logic [2:0] R_REQ  = 3'd3;
    localparam logic [2:0] R_WAIT = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_vld_p1;

    logic [31:0] fifo_addr  [DEPTH];
    logic [1:0]  fifo_size  [DEPTH];
    logic [31:0] fifo_wdata [DEPTH];
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;

    logic wr_acc;
    logic rd_acc;
    logic pop;

    // Gating with resetn keeps addr_ok low while reset is held, even with s.req high.
    assign wr_acc = resetn & s.req & s.wr & (count != FULL_CNT)
                    & (state != R_REQ) & (state != R_WAIT);
    assign rd_acc = resetn & s.req & ~s.wr & (state == IDLE) & (count == '0);
    assign pop    = (state == W_WAIT) & m.data_ok;

    assign s.addr_ok = wr_acc | rd_acc;
    assign s.data_ok = wr_vld_p1 | ((state == R_WAIT) & m.data_ok);
    assign s.rdata   = ((state == R_WAIT) & m.data_ok) ? m.rdata : '0;
    assign buf_empty = (count == '0) & (state == IDLE);

    always_comb begin
        m.req   = 1'b0;
        m.wr    = 1'b0;
        m.size  = '0;
        m.addr  = '0;
        m.wdata = '0;
        case (state)
            W_REQ: begin
                m.req   = 1'b1;
                m.wr    = 1'b1;
                m.size  = fifo_size[rd_ptr];
                m.addr  = fifo_addr[rd_ptr];
                m.wdata = fifo_wdata[rd_ptr];
            end
            R_REQ: begin
                m.req  = 1'b1;
                m.size = rd_size;
                m.addr = rd_addr;
            end
            default: ;
        endcase
    end

    // A write accepted while idle goes straight to W_REQ so it drains next cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if ((count != '0) || wr_acc) state_nx = W_REQ;
                else if (rd_acc)             state_nx = R_REQ;
            end
            W_REQ:   if (m.addr_ok) state_nx = W_WAIT;
            W_WAIT:  if (m.data_ok) state_nx = IDLE;
            R_REQ:   if (m.addr_ok) state_nx = R_WAIT;
            R_WAIT:  if (m.data_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_vld_p1 <= wr_acc;
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_acc && !pop)      count <= count + CNT_W'(1);
            else if (!wr_acc && pop) count <= count - CNT_W'(1);
        end
    end

    // Storage holds data only; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            fifo_addr[wr_ptr]  <= s.addr;
            fifo_size[wr_ptr]  <= s.size;
            fifo_wdata[wr_ptr] <= s.wdata;
        end
        if (rd_acc) begin
            rd_addr <= s.addr;
            rd_size <= s.size;
        end
    end

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed bench for data_write_buffer: a latency-programmable downstream
// responder with a small memory, and hand-computed cycle expectations.
module tb_data_write_buffer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic buf_empty;

    always #5 clk = ~clk;

    data_write_buffer_if up();
    data_write_buffer_if dn();

    data_write_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s         (up),
        .m         (dn),
        .buf_empty (buf_empty)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Downstream responder: addr_ok follows dn_auto, data_ok comes dn_lat cycles after a handshake.
    bit          dn_auto = 1'b0;
    int          dn_lat = 1;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    bit          pend_wr = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_wdata = '0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [31:0] log_wdata [$];

    initial begin
        dn.addr_ok = 1'b0;
        dn.data_ok = 1'b0;
        dn.rdata   = '0;
        forever begin
            @(posedge clk); #2;
            dn.addr_ok = dn_auto;
            dn.data_ok = 1'b0;
            dn.rdata   = '0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    dn.data_ok = 1'b1;
                    if (pend_wr) mem[pend_addr] = pend_wdata;
                    else dn.rdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            @(negedge clk);
            if (dn.req && dn.addr_ok) begin
                pend       = 1'b1;
                pend_cnt   = dn_lat;
                pend_wr    = dn.wr;
                pend_addr  = dn.addr;
                pend_wdata = dn.wdata;
                log_addr.push_back(dn.addr);
                log_wdata.push_back(dn.wdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic put(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        up.req   = req;
        up.wr    = wr;
        up.size  = 2'd2;
        up.addr  = a;
        up.wdata = d;
    endtask

    task automatic wait_drain(input string tag);
        int j;
        j = 0;
        while (buf_empty !== 1'b1 && j < 100) begin
            cyc();
            j++;
        end
        check(tag, 32'(buf_empty), 32'd1);
    endtask

    int acc_at;
    int done_at;
    int viol;
    logic [31:0] rd_got;

    initial begin
        // Reset: upstream request held high must not be accepted.
        put(1'b1, 1'b1, 32'h55, 32'h66);
        @(negedge clk);
        check("rst_addr_ok", 32'(up.addr_ok), 32'd0);
        check("rst_data_ok", 32'(up.data_ok), 32'd0);
        check("rst_rdata",   up.rdata, 32'd0);
        check("rst_m_req",   32'(dn.req), 32'd0);
        check("rst_m_wr",    32'(dn.wr), 32'd0);
        check("rst_m_size",  32'(dn.size), 32'd0);
        check("rst_m_addr",  dn.addr, 32'd0);
        check("rst_m_wdata", dn.wdata, 32'd0);
        check("rst_empty",   32'(buf_empty), 32'd1);
        up.req = 1'b0;
        @(posedge clk); #1;
        resetn  = 1'b1;
        dn_auto = 1'b1;
        dn_lat  = 1;

        // Single write with immediate downstream acks.
        put(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF);
        @(negedge clk);
        check("w1_addr_ok", 32'(up.addr_ok), 32'd1);
        check("w1_data_ok0", 32'(up.data_ok), 32'd0);
        cyc();
        up.req = 1'b0;
        @(negedge clk);
        check("w1_data_ok1", 32'(up.data_ok), 32'd1);
        check("w1_m_req",    32'(dn.req), 32'd1);
        check("w1_m_wr",     32'(dn.wr), 32'd1);
        check("w1_m_addr",   dn.addr, 32'h1000);
        check("w1_m_wdata",  dn.wdata, 32'hDEADBEEF);
        check("w1_m_size",   32'(dn.size), 32'd2);
        cyc();
        @(negedge clk);
        check("w1_wait_req",   32'(dn.req), 32'd0);
        check("w1_wait_empty", 32'(buf_empty), 32'd0);
        cyc();
        @(negedge clk);
        check("w1_empty", 32'(buf_empty), 32'd1);
        cyc();

        // Fill with downstream stalled, fifth write blocked until the first pop.
        dn_auto = 1'b0;
        log_addr.delete();
        log_wdata.delete();
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1'b1, i * 4, 32'hA0000000 | i);
            @(negedge clk);
            check("fill_acc", 32'(up.addr_ok), 32'd1);
            cyc();
        end
        put(1'b1, 1'b1, 32'h10, 32'hA0000004);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_block", 32'(up.addr_ok), 32'd0);
            cyc();
        end
        dn_auto = 1'b1;
        acc_at = -1;
        for (int j = 0; j < 20 && acc_at < 0; j++) begin
            @(negedge clk);
            if (up.addr_ok) acc_at = j;
            cyc();
        end
        up.req = 1'b0;
        check("full_accept_cycle", acc_at, 32'd2);
        wait_drain("fill_drain");
        check("fill_count", log_addr.size(), 32'd5);
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            check("fill_order_addr",  log_addr[i], i * 4);
            check("fill_order_wdata", log_wdata[i], 32'hA0000000 | i);
        end

        // Read after write, downstream latency 3.
        dn_lat = 3;
        put(1'b1, 1'b1, 32'h2000, 32'h12345678);
        @(negedge clk);
        check("raw_w_acc", 32'(up.addr_ok), 32'd1);
        cyc();
        put(1'b1, 1'b0, 32'h2000, 32'h0);
        acc_at = -1;
        for (int j = 1; j < 30 && acc_at < 0; j++) begin
            @(negedge clk);
            if (up.addr_ok) acc_at = j;
            cyc();
        end
        up.req = 1'b0;
        check("raw_rd_accept_cycle", acc_at, 32'd5);
        @(negedge clk);
        check("raw_m_req",   32'(dn.req), 32'd1);
        check("raw_m_wr",    32'(dn.wr), 32'd0);
        check("raw_m_addr",  dn.addr, 32'h2000);
        check("raw_m_wdata", dn.wdata, 32'h0);
        check("raw_rdata_idle", up.rdata, 32'h0);
        cyc();
        done_at = -1;
        rd_got = '0;
        for (int j = 7; j < 30 && done_at < 0; j++) begin
            @(negedge clk);
            if (up.data_ok) begin
                done_at = j;
                rd_got  = up.rdata;
            end
            cyc();
        end
        check("raw_rd_done_cycle", done_at, 32'd9);
        check("raw_rdata", rd_got, 32'h12345678);
        wait_drain("raw_drain");

        // Wrap-around: ten writes, each drained before the next.
        dn_lat = 1;
        log_addr.delete();
        log_wdata.delete();
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 1'b1, 32'h300 + i * 4, 32'h11111111 * i);
            acc_at = -1;
            for (int j = 0; j < 10 && acc_at < 0; j++) begin
                @(negedge clk);
                if (up.addr_ok) acc_at = j;
                cyc();
            end
            up.req = 1'b0;
            check("wrap_accept", acc_at, 32'd0);
            wait_drain("wrap_drain");
            if (log_addr.size() == i + 1) begin
                check("wrap_addr",  log_addr[i], 32'h300 + i * 4);
                check("wrap_wdata", log_wdata[i], 32'h11111111 * i);
            end else begin
                check("wrap_log_size", log_addr.size(), i + 1);
            end
        end

        // Reset while draining: three writes buffered, reset during W_WAIT.
        dn_auto = 1'b0;
        dn_lat  = 5;
        log_addr.delete();
        log_wdata.delete();
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 1'b1, 32'h400 + i * 4, 32'hC0DE0000 | i);
            @(negedge clk);
            check("mid_fill_acc", 32'(up.addr_ok), 32'd1);
            cyc();
        end
        up.req  = 1'b0;
        dn_auto = 1'b1;
        cyc();
        check("mid_handshake", log_addr.size(), 32'd1);
        put(1'b1, 1'b1, 32'h500, 32'h1);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_m_req",   32'(dn.req), 32'd0);
        check("mid_rst_m_addr",  dn.addr, 32'd0);
        check("mid_rst_addr_ok", 32'(up.addr_ok), 32'd0);
        check("mid_rst_data_ok", 32'(up.data_ok), 32'd0);
        check("mid_rst_empty",   32'(buf_empty), 32'd1);
        cyc();
        up.req = 1'b0;
        cyc();
        resetn = 1'b1;
        viol = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (dn.req || !buf_empty || up.data_ok) viol++;
            cyc();
        end
        check("post_rst_quiet", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
